ajuste_contadores_frec_ct: RTL
==============================

Name: ajuste_contadores_frec_ct

Overview:
User-input front end for the numeric display path. It synchronises and debounces three push-buttons (up, down, function) and holds the frequency index and duty-cycle (CT) counts. Its outputs cuenta_frec, cuenta_CT and funct_select feed the numeric-display controller (FSM plus BCD-to-7-segment converter) directly downstream.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples required before a level change is accepted (10 ms at 50 MHz)
FREC_MAX, 7, upper saturation value of cuenta_frec
CT_MAX, 10, upper saturation value of cuenta_CT (units of 10 % duty)
CT_RESET, 5, value cuenta_CT takes on reset

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
btn_up  in  1  raw, asynchronous push-button; increment
btn_down  in  1  raw, asynchronous push-button; decrement
btn_funct  in  1  raw, asynchronous push-button; toggles edited quantity
cuenta_frec  out  3  frequency index, 0..FREC_MAX
cuenta_CT  out  4  duty-cycle count, 0..CT_MAX
funct_select  out  1  0 = editing/displaying frequency, 1 = editing/displaying CT
cambio  out  1  one-cycle pulse whenever cuenta_frec, cuenta_CT or funct_select changes

Behaviour:
- Reset (reset = 0, asynchronous) values: cuenta_frec = 0, cuenta_CT = CT_RESET, funct_select = 0, cambio = 0.
- Reset also clears every synchroniser flop, debounce counter and debounce FSM to its idle/released state.
- Reset release is synchronous to clock: the first active edge after release behaves as normal operation.
- Each button passes through a 2-flop synchroniser, then its own debounce FSM.
- Debounce FSM states and transitions:
  - SOLTADO: sync = 1 -> CONTANDO_P, counter = 1.
  - CONTANDO_P: sync = 0 -> SOLTADO.
  - CONTANDO_P: counter reaches DEBOUNCE_CYCLES -> PRESIONADO, and a one-cycle press pulse is emitted.
  - PRESIONADO: sync = 0 -> CONTANDO_S, counter = 1.
  - CONTANDO_S: sync = 1 -> PRESIONADO.
  - CONTANDO_S: counter reaches DEBOUNCE_CYCLES -> SOLTADO.
- Exactly one press pulse per accepted press; holding a button gives no auto-repeat.
- Latency: the press pulse is asserted 2 + DEBOUNCE_CYCLES cycles after the raw input rises and stays stable. The counter update and cambio follow on the next edge.
- Press pulse on btn_funct: funct_select toggles.
- Up pulse: increments the selected counter; the counter saturates at its MAX (no wrap) and cambio is not asserted if the value is already at MAX.
- Down pulse: decrements the selected counter; the counter saturates at 0 (no wrap) and cambio is not asserted if the value is already 0.
- The non-selected counter always holds its value.
- Up and down press pulses in the same cycle: both are ignored, no change, cambio = 0.
- Function pulse in the same cycle as an up/down pulse: the up/down pulse applies to the counter selected by the old funct_select, and the toggle applies on the same edge. cambio = 1.
- Outputs are registered; no combinational path from any button input to any output.
- Counter width rule: the saturation compare uses the full output width. CT_MAX must be ≤ 15 and FREC_MAX ≤ 7, checked at elaboration.

Decomposition:
- Shared package/header: debounce state encodings (SOLTADO, CONTANDO_P, PRESIONADO, CONTANDO_S), DEBOUNCE counter width as clog2(DEBOUNCE_CYCLES + 1), and default FREC_MAX / CT_MAX / CT_RESET constants.
- Sub-module antirrebote_pulsador (synchroniser + debounce FSM + press pulse), instantiated three times.
- The top level holds only the counter/toggle logic.

Test Plan:
(Bench uses DEBOUNCE_CYCLES = 4.)
- Reset: hold reset = 0 for 3 cycles, buttons idle -> cuenta_frec = 0, cuenta_CT = 5, funct_select = 0, cambio = 0. Assert reset mid-cycle -> outputs change before the next clock edge.
- Bounce rejection: btn_up toggles 1-0-1-0 with 2-cycle periods, then settles high for 10 cycles -> exactly one increment, cuenta_frec 0 -> 1, cambio high exactly one cycle, appearing 7 cycles after the last rising edge.
- Frequency saturation: 9 clean up presses with funct_select = 0 -> cuenta_frec reaches 7 and stays 7; cambio pulses 7 times, not 9. 8 down presses -> cuenta_frec 0; cuenta_CT stays 5 throughout.
- Function toggle and CT editing: btn_funct press -> funct_select = 1. 6 up presses -> cuenta_CT 5 -> 10 (saturates, 5 cambio pulses). 11 down presses -> cuenta_CT 0.
- Simultaneous up and down: both buttons rise on the same cycle and stay stable -> no counter change, cambio stays 0. Hold for 100 cycles -> no auto-repeat.
- Reset mid-operation: assert reset while btn_up has been stable for 2 of 4 cycles, release reset with btn_up still high -> no increment until a full 4-cycle stable window plus sync delay elapses after reset release.

Source files
------------

// File: rtl/ajuste_contadores_frec_ct_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ajuste_contadores_frec_ct_pkg
// Purpose : Shared types and constants for the push-button front end of the
//           numeric display path: debounce state encoding, debounce counter
//           width helper and default counter limits.
// Ports   : (package, no ports)
// Revision: 1.0 - initial release
// ============================================================================
package ajuste_contadores_frec_ct_pkg;

  // Debounce FSM: released, counting towards pressed, pressed,
  // counting towards released.
  typedef enum logic [1:0] {
    SOLTADO    = 2'd0,
    CONTANDO_P = 2'd1,
    PRESIONADO = 2'd2,
    CONTANDO_S = 2'd3
  } deb_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_FREC_MAX        = 7;
  localparam int DEF_CT_MAX          = 10;
  localparam int DEF_CT_RESET        = 5;

  // The debounce counter must be able to hold DEBOUNCE_CYCLES itself.
  function automatic int deb_cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage : ajuste_contadores_frec_ct_pkg
`default_nettype wire

// File: rtl/antirrebote_pulsador.sv
`default_nettype none
// ============================================================================
// Module  : antirrebote_pulsador
// Purpose : Two-flop synchroniser plus debounce FSM for one raw push-button.
//           Emits a single-cycle registered pulse for every accepted press.
// Ports   : clock - system clock, rising edge
//           reset - asynchronous active-low reset
//           btn   - raw asynchronous button level
//           pulso - one-cycle press pulse (registered)
// Revision: 1.0 - initial release
// ============================================================================
module antirrebote_pulsador
  import ajuste_contadores_frec_ct_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic pulso
);

  localparam int W = deb_cnt_width(DEBOUNCE_CYCLES);
  // The count is already 1 on entry to a counting state, so the window is
  // complete when the count seen in-state reaches DEBOUNCE_CYCLES - 1.
  localparam logic [W-1:0] c_last = W'(DEBOUNCE_CYCLES - 1);
  localparam logic [W-1:0] c_one  = W'(1);

  logic            sync1_q;
  logic            sync2_q;
  deb_state_e      state_q;
  deb_state_e      state_d;
  logic [W-1:0]    cnt_q;
  logic [W-1:0]    cnt_d;
  logic            pulso_q;
  logic            pulso_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= SOLTADO;
      cnt_q   <= '0;
      pulso_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulso_q <= pulso_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulso_d = 1'b0;
    case (state_q)
      SOLTADO: begin
        if (sync2_q) begin
          state_d = CONTANDO_P;
          cnt_d   = c_one;
        end
      end
      CONTANDO_P: begin
        if (!sync2_q) begin
          state_d = SOLTADO;
        end else if (cnt_q >= c_last) begin
          state_d = PRESIONADO;
          pulso_d = 1'b1;
        end else begin
          cnt_d = cnt_q + c_one;
        end
      end
      PRESIONADO: begin
        if (!sync2_q) begin
          state_d = CONTANDO_S;
          cnt_d   = c_one;
        end
      end
      CONTANDO_S: begin
        if (sync2_q) begin
          state_d = PRESIONADO;
        end else if (cnt_q >= c_last) begin
          state_d = SOLTADO;
        end else begin
          cnt_d = cnt_q + c_one;
        end
      end
      default: begin
        state_d = SOLTADO;
      end
    endcase
  end

  assign pulso = pulso_q;

endmodule : antirrebote_pulsador
`default_nettype wire

// File: rtl/ajuste_contadores_frec_ct.sv
`default_nettype none
// ============================================================================
// Module  : ajuste_contadores_frec_ct
// Purpose : User-input front end of the numeric display path. Debounces the
//           up/down/function buttons and holds the saturating frequency
//           index and duty-cycle (CT) counters plus the edit selector.
// Ports   : clock        - system clock, rising edge
//           reset        - asynchronous active-low reset
//           btn_up       - raw button, increment selected counter
//           btn_down     - raw button, decrement selected counter
//           btn_funct    - raw button, toggle edited quantity
//           cuenta_frec  - frequency index 0..FREC_MAX
//           cuenta_CT    - duty-cycle count 0..CT_MAX
//           funct_select - 0 = frequency, 1 = CT
//           cambio       - one-cycle pulse on any output value change
// Revision: 1.0 - initial release
// ============================================================================
module ajuste_contadores_frec_ct
  import ajuste_contadores_frec_ct_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int FREC_MAX        = DEF_FREC_MAX,
  parameter int CT_MAX          = DEF_CT_MAX,
  parameter int CT_RESET        = DEF_CT_RESET
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_funct,
  output logic [2:0] cuenta_frec,
  output logic [3:0] cuenta_CT,
  output logic       funct_select,
  output logic       cambio
);

  if (FREC_MAX < 0 || FREC_MAX > 7) begin : g_bad_frec_max
    $error("FREC_MAX out of range 0..7");
  end
  if (CT_MAX < 0 || CT_MAX > 15) begin : g_bad_ct_max
    $error("CT_MAX out of range 0..15");
  end
  if (CT_RESET < 0 || CT_RESET > CT_MAX) begin : g_bad_ct_reset
    $error("CT_RESET out of range 0..CT_MAX");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  localparam logic [2:0] c_frec_max = 3'(FREC_MAX);
  localparam logic [3:0] c_ct_max   = 4'(CT_MAX);
  localparam logic [3:0] c_ct_reset = 4'(CT_RESET);

  logic       pulse_up;
  logic       pulse_down;
  logic       pulse_funct;

  logic [2:0] frec_q;
  logic [2:0] frec_d;
  logic [3:0] ct_q;
  logic [3:0] ct_d;
  logic       sel_q;
  logic       sel_d;
  logic       cambio_q;
  logic       cambio_d;

  antirrebote_pulsador #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clock (clock),
    .reset (reset),
    .btn   (btn_up),
    .pulso (pulse_up)
  );

  antirrebote_pulsador #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clock (clock),
    .reset (reset),
    .btn   (btn_down),
    .pulso (pulse_down)
  );

  antirrebote_pulsador #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_funct (
    .clock (clock),
    .reset (reset),
    .btn   (btn_funct),
    .pulso (pulse_funct)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frec_q   <= 3'd0;
      ct_q     <= c_ct_reset;
      sel_q    <= 1'b0;
      cambio_q <= 1'b0;
    end else begin
      frec_q   <= frec_d;
      ct_q     <= ct_d;
      sel_q    <= sel_d;
      cambio_q <= cambio_d;
    end
  end

  // Up/down act on the selector value held before this edge, so a
  // simultaneous function press only redirects subsequent presses.
  always_comb begin
    frec_d = frec_q;
    ct_d   = ct_q;
    sel_d  = sel_q;
    if (pulse_funct) begin
      sel_d = ~sel_q;
    end
    if (pulse_up && !pulse_down) begin
      if (!sel_q) begin
        if (frec_q < c_frec_max) frec_d = frec_q + 3'd1;
      end else begin
        if (ct_q < c_ct_max) ct_d = ct_q + 4'd1;
      end
    end else if (pulse_down && !pulse_up) begin
      if (!sel_q) begin
        if (frec_q != 3'd0) frec_d = frec_q - 3'd1;
      end else begin
        if (ct_q != 4'd0) ct_d = ct_q - 4'd1;
      end
    end
    // Derived from actual value changes, so saturated presses stay silent.
    cambio_d = (frec_d != frec_q) || (ct_d != ct_q) || (sel_d != sel_q);
  end

  assign cuenta_frec  = frec_q;
  assign cuenta_CT    = ct_q;
  assign funct_select = sel_q;
  assign cambio       = cambio_q;

endmodule : ajuste_contadores_frec_ct
`default_nettype wire
